// File: rtl/posit_mult_arbiter.sv
// posit_mult_arbiter: arbitrates two posit-multiply requesters onto one
// shared pipelined positmult unit and steers each result back to the
// requester that issued it.
//
// Ports
//   clk, rst                      clock; synchronous active-high reset
//   reqX_valid, reqX_in1/in2      requester X operand pair (X = 0,1)
//   reqX_ready                    grant, combinational from valids + priority
//   mul_in1, mul_in2, mul_start   issue to the shared multiplier
//   mul_result, mul_inf,
//   mul_zero, mul_done            multiplier outputs, LATENCY cycles after issue
//   rspX_valid                    one-cycle result strobe for requester X
//   rsp_result, rsp_inf, rsp_zero shared response data, held between strobes
//   busy                          any operation in flight
//   err                           sticky mul_done / tag mismatch flag
//
// Optional feature: define POSIT_MULT_ARBITER_DONE_CHECK_EN to compare
// mul_done against the output-stage tag every cycle; without it mul_done is
// ignored and err is tied low.
module posit_mult_arbiter #(
  parameter int unsigned N       = 32,
  parameter int unsigned ES      = 2,
  parameter int unsigned LATENCY = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic         req1_valid,
  input  logic [N-1:0] req0_in1,
  input  logic [N-1:0] req0_in2,
  input  logic [N-1:0] req1_in1,
  input  logic [N-1:0] req1_in2,
  output logic         req0_ready,
  output logic         req1_ready,
  output logic [N-1:0] mul_in1,
  output logic [N-1:0] mul_in2,
  output logic         mul_start,
  input  logic [N-1:0] mul_result,
  input  logic         mul_inf,
  input  logic         mul_zero,
  input  logic         mul_done,
  output logic         rsp0_valid,
  output logic         rsp1_valid,
  output logic [N-1:0] rsp_result,
  output logic         rsp_inf,
  output logic         rsp_zero,
  output logic         busy,
  output logic         err
);

  localparam int unsigned TAG_OUT = LATENCY - 1;

  typedef enum logic {
    PRI_REQ0 = 1'b0,
    PRI_REQ1 = 1'b1
  } prio_t;

  prio_t              prio;
  logic               grant0;
  logic               grant1;
  logic [LATENCY-1:0] tag_valid;
  logic [LATENCY-1:0] tag_id;

  // ES only describes the operand format seen by the multiplier.
  logic [31:0] es_unused;
  assign es_unused = 32'(ES);

  // Grant: a lone requester wins at once; on contention the pointer decides.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      grant0 = req0_valid & (!req1_valid | (prio == PRI_REQ0));
      grant1 = req1_valid & (!req0_valid | (prio == PRI_REQ1));
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign mul_start  = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  // Operand steering; zero when nothing is issued.
  always_comb begin
    mul_in1 = '0;
    mul_in2 = '0;
    if (grant0) begin
      mul_in1 = req0_in1;
      mul_in2 = req0_in2;
    end else if (grant1) begin
      mul_in1 = req1_in1;
      mul_in2 = req1_in2;
    end
  end

  // Pointer, tag pipeline (bit 0 = newest issue) and response stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio       <= PRI_REQ0;
      tag_valid  <= '0;
      tag_id     <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_result <= '0;
      rsp_inf    <= 1'b0;
      rsp_zero   <= 1'b0;
    end else begin
      // Round-robin only moves when both contended for the slot.
      if (req0_valid & req1_valid) begin
        prio <= (prio == PRI_REQ0) ? PRI_REQ1 : PRI_REQ0;
      end
      tag_valid  <= (tag_valid << 1) | LATENCY'(mul_start);
      tag_id     <= (tag_id << 1) | LATENCY'(grant1);
      rsp0_valid <= tag_valid[TAG_OUT] & ~tag_id[TAG_OUT];
      rsp1_valid <= tag_valid[TAG_OUT] & tag_id[TAG_OUT];
      // Data only updates on a real result so it holds between strobes.
      if (tag_valid[TAG_OUT]) begin
        rsp_result <= mul_result;
        rsp_inf    <= mul_inf;
        rsp_zero   <= mul_zero;
      end
    end
  end

  assign busy = (|tag_valid) | rsp0_valid | rsp1_valid;

`ifdef POSIT_MULT_ARBITER_DONE_CHECK_EN
  // Multiplier must signal done exactly when a tagged op reaches the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (mul_done != tag_valid[TAG_OUT]) begin
      err <= 1'b1;
    end
  end
`else
  logic done_unused;
  assign done_unused = mul_done;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_posit_mult_arbiter.sv
// Bench for posit_mult_arbiter: stand-in multiplier, arbitration reference,
// and a response scoreboard keyed by issue cycle.
module tb_posit_mult_arbiter;

  localparam int unsigned N   = 32;
  localparam int unsigned LAT = 4;
  localparam logic [31:0] P_ZERO = 32'h0000_0000;
  localparam logic [31:0] P_NAR  = 32'h8000_0000;
  localparam logic [31:0] P_ONE  = 32'h4000_0000;
  localparam logic [31:0] P_TWO  = 32'h4800_0000;

  logic         clk;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic [N-1:0] req0_in1, req0_in2, req1_in1, req1_in2;
  logic         req0_ready, req1_ready;
  logic [N-1:0] mul_in1, mul_in2;
  logic         mul_start;
  logic [N-1:0] mul_result;
  logic         mul_inf, mul_zero, mul_done;
  logic         rsp0_valid, rsp1_valid;
  logic [N-1:0] rsp_result;
  logic         rsp_inf, rsp_zero;
  logic         busy, err;

  posit_mult_arbiter #(.N(N), .ES(2), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_in1(req0_in1), .req0_in2(req0_in2),
    .req1_in1(req1_in1), .req1_in2(req1_in2),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_start(mul_start),
    .mul_result(mul_result), .mul_inf(mul_inf), .mul_zero(mul_zero),
    .mul_done(mul_done),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_result(rsp_result), .rsp_inf(rsp_inf), .rsp_zero(rsp_zero),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  // Stand-in positmult: exact for NaR, zero and unity operands; any other
  // pair gets a deterministic scramble so misrouted operands show up.
  function automatic logic [33:0] pmul(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] p;
    if (a == P_NAR || b == P_NAR)        return {1'b1, 1'b0, P_NAR};
    else if (a == P_ZERO || b == P_ZERO) return {1'b0, 1'b1, P_ZERO};
    else if (a == P_ONE)                 return {1'b0, 1'b0, b};
    else if (b == P_ONE)                 return {1'b0, 1'b0, a};
    p = 32'(a * b) ^ {b[15:0], a[31:16]};
    return {1'b0, 1'b0, p};
  endfunction

  // Environment multiplier: fixed LAT-cycle pipeline.
  logic         withhold;
  logic [LAT-1:0] mp_d;
  logic [33:0]  mp_pay [LAT];
  always_ff @(posedge clk) begin
    if (rst) begin
      mp_d <= '0;
    end else begin
      mp_d <= {mp_d[LAT-2:0], mul_start & ~withhold};
    end
    for (int i = LAT - 1; i > 0; i--) mp_pay[i] <= mp_pay[i-1];
    mp_pay[0] <= pmul(mul_in1, mul_in2);
  end
  assign mul_result = mp_pay[LAT-1][31:0];
  assign mul_zero   = mp_pay[LAT-1][32];
  assign mul_inf    = mp_pay[LAT-1][33];
  assign mul_done   = mp_d[LAT-1];

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        inf;
    logic        zero;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   prio_m = 0;
  logic armed  = 1'b0;

  // Issue monitor: reference arbitration; pushes the expected response.
  initial begin
    logic  e0, e1;
    logic [33:0] r;
    exp_t  it;
    forever begin
      @(negedge clk);
      #1;
      e0 = 1'b0;
      e1 = 1'b0;
      if (!rst) begin
        if (req0_valid && req1_valid) begin
          e0 = (prio_m == 0);
          e1 = (prio_m == 1);
        end else begin
          e0 = req0_valid;
          e1 = req1_valid;
        end
      end
      check("req0_ready", req0_ready, e0);
      check("req1_ready", req1_ready, e1);
      check("mul_start", mul_start, e0 | e1);
      check("mul_in1", mul_in1, e0 ? req0_in1 : (e1 ? req1_in1 : 32'h0));
      check("mul_in2", mul_in2, e0 ? req0_in2 : (e1 ? req1_in2 : 32'h0));
      if (e0 || e1) begin
        r       = e0 ? pmul(req0_in1, req0_in2) : pmul(req1_in1, req1_in2);
        it.id   = e0 ? 0 : 1;
        it.res  = r[31:0];
        it.zero = r[32];
        it.inf  = r[33];
        it.cyc  = cyc;
        sb.push_back(it);
      end
      if (rst) begin
        sb.delete();
        prio_m = 0;
      end else if (req0_valid && req1_valid) begin
        prio_m = 1 - prio_m;
      end
    end
  end

  // Response monitor: pops and compares whenever a strobe appears.
  initial begin
    logic [31:0] last_res;
    logic        last_inf, last_zero, busy_m, due, err_m;
    exp_t        it;
    last_res  = '0;
    last_inf  = 1'b0;
    last_zero = 1'b0;
    err_m     = 1'b0;
    forever begin
      @(negedge clk);
      busy_m = 1'b0;
      due    = 1'b0;
      foreach (sb[i]) begin
        if (sb[i].cyc < cyc) busy_m = 1'b1;
        if (sb[i].cyc + int'(LAT) == cyc) due = 1'b1;
      end
      if (armed) begin
        check("rsp_onehot", rsp0_valid & rsp1_valid, 1'b0);
        check("busy", busy, busy_m);
        check("err", err, err_m);
        if (rsp0_valid || rsp1_valid) begin
          if (sb.size() == 0) begin
            check("rsp_unexpected", 1'b1, 1'b0);
          end else begin
            it = sb.pop_front();
            check("rsp_id", rsp1_valid, it.id == 1);
            check("rsp_latency", 64'(cyc - it.cyc), 64'(LAT + 1));
            check("rsp_result", rsp_result, it.res);
            check("rsp_inf", rsp_inf, it.inf);
            check("rsp_zero", rsp_zero, it.zero);
            last_res  = it.res;
            last_inf  = it.inf;
            last_zero = it.zero;
          end
        end else begin
          check("rsp_hold", {rsp_inf, rsp_zero, rsp_result}, {last_inf, last_zero, last_res});
        end
      end
`ifdef POSIT_MULT_ARBITER_DONE_CHECK_EN
      if (rst) err_m = 1'b0;
      else if (mul_done !== due) err_m = 1'b1;
`endif
      if (rst) begin
        armed     = 1'b1;
        last_res  = '0;
        last_inf  = 1'b0;
        last_zero = 1'b0;
      end
    end
  end

  task automatic step(input logic v0, input logic v1,
                      input logic [31:0] a0, input logic [31:0] b0,
                      input logic [31:0] a1, input logic [31:0] b1);
    req0_valid = v0;
    req1_valid = v1;
    req0_in1   = a0;
    req0_in2   = b0;
    req1_in1   = a1;
    req1_in2   = b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 9))
      0:       return P_ZERO;
      1:       return P_NAR;
      2:       return P_ONE;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst      = 1'b1;
    withhold = 1'b0;
    // Valids held high during reset: no grant may leak out.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, P_ONE, P_TWO, P_TWO, P_ONE);
    rst = 1'b0;
    idle(2);

    // 1.0 x 2.0 from requester 0 alone.
    step(1'b1, 1'b0, P_ONE, P_TWO, '0, '0);
    idle(7);
    // zero x NaR from requester 1 alone.
    step(1'b0, 1'b1, '0, '0, P_ZERO, P_NAR);
    idle(7);

    // Contention: grants must alternate starting with requester 0.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, rand_op(), rand_op(), rand_op(), rand_op());
    idle(6);

    // Full-rate single requester.
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, rand_op(), rand_op(), '0, '0);
    idle(6);

    // Random traffic.
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           rand_op(), rand_op(), rand_op(), rand_op());
    idle(6);

    // One op whose done strobe goes missing.
    withhold = 1'b1;
    step(1'b1, 1'b0, rand_op(), rand_op(), '0, '0);
    withhold = 1'b0;
    idle(10);

    // Three issues (first one contended, moving the pointer), then reset.
    step(1'b1, 1'b1, rand_op(), rand_op(), rand_op(), rand_op());
    step(1'b1, 1'b0, rand_op(), rand_op(), '0, '0);
    step(1'b1, 1'b0, rand_op(), rand_op(), '0, '0);
    idle(1);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(8);
    // Pointer must be back at requester 0.
    step(1'b1, 1'b1, rand_op(), rand_op(), rand_op(), rand_op());
    idle(12);

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/posit_mult_arbiter.md
POSIT_MULT_ARBITER -- requirements
Module: posit_mult_arbiter

Interface
REQ-001 Parameter: N, 32, posit word width.
REQ-002 Parameter: ES, 2, posit exponent size; passed through only, never used in arbiter logic.
REQ-003 Parameter: LATENCY, 4, multiplier cycles from mul_start to the matching mul_result.
REQ-004 Port: clk  input  1  sole clock; all state on rising edge.
REQ-005 Port: rst  input  1  reset; synchronous, active-high.
REQ-006 Ports: req0_valid/req1_valid  input  1 each  requester operand pair valid.
REQ-007 Ports: req0_in1, req0_in2, req1_in1, req1_in2  input  N each  posit operands.
REQ-008 Ports: req0_ready/req1_ready  output  1 each  grant; handshake = valid & ready in the same cycle.
REQ-009 Ports: mul_in1, mul_in2  output  N each  operands to the shared positmult pipeline.
REQ-010 Port: mul_start  output  1  issue strobe to the multiplier.
REQ-011 Ports: mul_result  input  N; mul_inf, mul_zero, mul_done  input  1 each  multiplier outputs.
REQ-012 Ports: rsp0_valid/rsp1_valid  output  1 each  one-cycle result strobe per requester; no back-pressure.
REQ-013 Ports: rsp_result  output  N; rsp_inf, rsp_zero  output  1 each  shared response data, qualified by rspX_valid.
REQ-014 Ports: busy  output  1  any op in flight; err  output  1  sticky done-mismatch flag.

Function
REQ-015 At most one handshake per cycle; a lone valid requester is granted in that same cycle (readyX combinational from validX and priority).
REQ-016 Both valid: grant the requester with priority; the priority pointer then points to the other requester (round-robin); pointer unchanged on a lone grant or idle cycle.
REQ-017 mul_in1/mul_in2 SHALL equal the granted requester's operands combinationally; mul_start = req0_ready&req0_valid | req1_ready&req1_valid; with no grant, mul_in1/mul_in2 = 0.
REQ-018 A tag shift register of depth LATENCY SHALL record {valid, requester id} per issue cycle, shifting every cycle regardless of grants.
REQ-019 When the tag for cycle t reaches the output (cycle t+LATENCY), mul_result/mul_inf/mul_zero SHALL be registered into rsp_* and the matching rspX_valid asserted in cycle t+LATENCY+1; total latency = LATENCY+1 cycles from the handshake.
REQ-020 Back-to-back issue every cycle SHALL be supported; responses return in issue order, one per cycle, never both rsp0_valid and rsp1_valid at once.
REQ-021 rsp_result/rsp_inf/rsp_zero hold their last value when no rspX_valid is asserted.
REQ-022 busy = OR of all tag valid bits plus the rsp-stage valid.

Reset
REQ-023 rst SHALL clear all tag valids, rsp0_valid=rsp1_valid=0, rsp_result=0, rsp_inf=rsp_zero=0, err=0, and set the priority pointer to requester 0.
REQ-024 While rst is high, req0_ready=req1_ready=0 and mul_start=0.
REQ-025 rst mid-operation SHALL discard in-flight ops: no rspX_valid for any op issued before the reset cycle.

Configuration
REQ-026 Macro POSIT_MULT_ARBITER_DONE_CHECK_EN defined: each cycle where mul_done differs from the output-stage tag valid sets err, which holds until rst.
REQ-027 Macro undefined: mul_done is ignored and err is tied to 0.

Verification
REQ-028 Only req0 valid with in1=32'h40000000 (1.0), in2=32'h48000000 (2.0), LATENCY=4 -> behavioural model returns result 32'h48000000 -> rsp0_valid in cycle 5, rsp_result=32'h48000000, rsp_inf=0, rsp_zero=0.
REQ-029 Both requesters held valid 8 cycles after reset -> grants alternate 0,1,0,1...; rsp0/rsp1 strobes alternate with matching results.
REQ-030 Continuous req0 issue with req1 idle -> one grant per cycle, 100% throughput, results in order, busy high throughout.
REQ-031 Operand 32'h00000000 (zero) x 32'h80000000 (NaR) through model -> rsp_inf/rsp_zero mirror model's mul_inf/mul_zero in cycle 5.
REQ-032 rst asserted 2 cycles after 3 issues -> no rsp strobes follow, busy=0 and pointer=req0 after reset.
REQ-033 With POSIT_MULT_ARBITER_DONE_CHECK_EN defined, model withholds mul_done for one issued op -> err rises the cycle after the mismatch and stays set until rst.
